// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: stores queue bytes in a small FIFO, a serial FSM
// shifts them out LSB first; loads return TXDATA/STATUS/DIV combinationally.
module uart_tx_mmio #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Mem_Write_i,
    input  logic        Mem_Read_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    output logic [31:0] Read_Data_o,
    output logic        uart_tx_o,
    output logic        irq_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            ovf_q;
    logic [15:0]     div_q;

    state_e          state_q;
    logic [7:0]      shift_q;
    logic [2:0]      bit_idx_q;
    logic [15:0]     baud_q;
    logic [15:0]     div_lat_q;
    logic            tx_q;

    logic full, empty, wr_tx, wr_status, wr_div, bit_end, pop, push;
    logic unused;

    assign full      = (count_q == CntW'(FIFO_DEPTH));
    assign empty     = (count_q == '0);
    assign wr_tx     = Mem_Write_i && (Address_i[3:2] == 2'd0);
    assign wr_status = Mem_Write_i && (Address_i[3:2] == 2'd1);
    assign wr_div    = Mem_Write_i && (Address_i[3:2] == 2'd2);
    assign bit_end   = (baud_q == div_lat_q - 16'd1);
    // The FSM consumes a byte either from IDLE or at the last STOP cycle (back-to-back).
    assign pop       = !empty && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
    assign push      = wr_tx && (!full || pop);
    assign unused    = ^{Address_i[31:4], Address_i[1:0], Write_Data_i[31:16]};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= Write_Data_i[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DEFAULT_DIV;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
            if (wr_tx && full && !pop) begin
                ovf_q <= 1'b1;
            end else if (wr_status && Write_Data_i[3]) begin
                ovf_q <= 1'b0;
            end
            if (wr_div) begin
                div_q <= Write_Data_i[15:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            shift_q   <= '0;
            bit_idx_q <= '0;
            baud_q    <= '0;
            div_lat_q <= 16'd1;
            tx_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_q <= 1'b1;
                    if (pop) begin
                        shift_q   <= fifo_q[rd_ptr_q];
                        div_lat_q <= (div_q == 16'd0) ? 16'd1 : div_q;
                        baud_q    <= '0;
                        tx_q      <= 1'b0;
                        state_q   <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        state_q   <= StData;
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q   <= fifo_q[rd_ptr_q];
                            div_lat_q <= (div_q == 16'd0) ? 16'd1 : div_q;
                            tx_q      <= 1'b0;
                            state_q   <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + 16'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        Read_Data_o = 32'h0;
        if (Mem_Read_i) begin
            case (Address_i[3:2])
                2'd1:    Read_Data_o = {28'h0, ovf_q, empty, full, state_q != StIdle};
                2'd2:    Read_Data_o = {16'h0, div_q};
                default: Read_Data_o = 32'h0;
            endcase
        end
    end

    assign uart_tx_o = tx_q;
    assign irq_o     = empty && (state_q == StIdle);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: register-access vector table plus a serial-line monitor that
// checks every frame against a scoreboard of expected {byte, divisor} pairs.
module tb_uart_tx_mmio;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Mem_Write_i = 1'b0;
    logic        Mem_Read_i = 1'b0;
    logic [31:0] Address_i = 32'h0;
    logic [31:0] Write_Data_i = 32'h0;
    logic [31:0] Read_Data_o;
    logic        uart_tx_o;
    logic        irq_o;

    uart_tx_mmio #(
        .FIFO_DEPTH (4),
        .DEFAULT_DIV(16'd434)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Mem_Write_i (Mem_Write_i),
        .Mem_Read_i  (Mem_Read_i),
        .Address_i   (Address_i),
        .Write_Data_i(Write_Data_i),
        .Read_Data_o (Read_Data_o),
        .uart_tx_o   (uart_tx_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [7:0] data;
        int         dv;
    } exp_t;

    typedef struct packed {
        logic        do_wr;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        rd;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    exp_t exp_q[$];
    int   starts[$];
    int   frames = 0;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        Mem_Write_i  = 1'b1;
        Address_i    = a;
        Write_Data_i = d;
        @(posedge clk);
        #1;
        Mem_Write_i = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        Mem_Read_i = 1'b1;
        Address_i  = a;
        #1;
        check(name, Read_Data_o, exp);
        Mem_Read_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] b, input int dv, input bit accept);
        exp_t e;
        e.data = b;
        e.dv   = dv;
        if (accept) exp_q.push_back(e);
        bus_wr(32'h0, {24'h0, b});
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (frames < target && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("frames_done", frames, target);
        @(posedge clk);
        #1;
    endtask

    function automatic logic bit_of(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        else if (idx == 9) return 1'b1;
        else return d[idx-1];
    endfunction

    // Line monitor: a low sample while idle is a start bit; sample every cycle of the frame.
    initial begin : monitor
        exp_t e;
        int   start_cyc;
        int   bad_i;
        bit   aborted;
        forever begin
            @(negedge clk);
            if (reset && uart_tx_o == 1'b0) begin
                start_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'h1, 32'h0);
                    while (uart_tx_o == 1'b0) @(negedge clk);
                end else begin
                    e       = exp_q.pop_front();
                    bad_i   = -1;
                    aborted = 1'b0;
                    for (int i = 0; i < 10 * e.dv; i++) begin
                        if (i > 0) @(negedge clk);
                        if (!reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (bad_i < 0 && uart_tx_o !== bit_of(e.data, i / e.dv)) bad_i = i;
                    end
                    if (!aborted) begin
                        frames++;
                        starts.push_back(start_cyc);
                        n_vec++;
                        if (bad_i >= 0) begin
                            n_err++;
                            $display("FAIL frame %02h div %0d: line wrong at sample %0d, start cycle %0d",
                                     e.data, e.dv, bad_i, start_cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int e_cyc;
        int f0;
        int n;
        int stray;

        vecs[0] = '{1'b0, 32'h0,  32'h0,         1'b1, 32'h4,  32'h4};
        vecs[1] = '{1'b0, 32'h0,  32'h0,         1'b1, 32'h0,  32'h0};
        vecs[2] = '{1'b0, 32'h0,  32'h0,         1'b1, 32'h8,  32'h1B2};
        vecs[3] = '{1'b1, 32'h8,  32'hDEAD_5678, 1'b1, 32'h8,  32'h5678};
        vecs[4] = '{1'b1, 32'hC,  32'hFFFF_FFFF, 1'b1, 32'hC,  32'h0};
        vecs[5] = '{1'b0, 32'h0,  32'h0,         1'b1, 32'h8,  32'h5678};
        vecs[6] = '{1'b1, 32'h4,  32'hFFFF_FFFF, 1'b1, 32'h4,  32'h4};
        vecs[7] = '{1'b0, 32'h0,  32'h0,         1'b0, 32'h8,  32'h0};
        vecs[8] = '{1'b0, 32'h0,  32'h0,         1'b1, 32'h18, 32'h5678};
        vecs[9] = '{1'b1, 32'h18, 32'h0000_0004, 1'b1, 32'h8,  32'h4};

        #1 reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_tx", uart_tx_o, 1);
        check("rst_irq", irq_o, 1);
        check("rst_rdata", Read_Data_o, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            if (vecs[i].do_wr) bus_wr(vecs[i].wa, vecs[i].wd);
            Mem_Read_i = vecs[i].rd;
            Address_i  = vecs[i].ra;
            #1;
            check($sformatf("vec%0d", i), Read_Data_o, vecs[i].exp);
            Mem_Read_i = 1'b0;
        end

        // Single frame, DIV=4
        f0 = frames;
        push(8'h55, 4, 1'b1);
        e_cyc = cyc;
        check("t1_irq_busy", irq_o, 0);
        wait_frames(f0 + 1, 200);
        check("t1_start_latency", starts[starts.size()-1], e_cyc + 1);
        check("t1_irq_done", irq_o, 1);

        // Three back-to-back frames, DIV=2
        bus_wr(32'h8, 32'h2);
        f0 = frames;
        push(8'hA1, 2, 1'b1);
        push(8'h02, 2, 1'b1);
        push(8'h03, 2, 1'b1);
        rd_chk("t2_status_busy", 32'h4, 32'h1);
        wait_frames(f0 + 3, 300);
        n = starts.size();
        check("t2_gap1", starts[n-2] - starts[n-3], 20);
        check("t2_gap2", starts[n-1] - starts[n-2], 20);
        rd_chk("t2_status_end", 32'h4, 32'h4);

        // Overflow, DIV=100
        bus_wr(32'h8, 32'd100);
        f0 = frames;
        push(8'h10, 100, 1'b1);
        push(8'h11, 100, 1'b1);
        push(8'h12, 100, 1'b1);
        push(8'h13, 100, 1'b1);
        push(8'h14, 100, 1'b1);
        rd_chk("t3_status_full", 32'h4, 32'h3);
        push(8'h15, 100, 1'b0);
        rd_chk("t3_status_ovf", 32'h4, 32'hB);
        bus_wr(32'h4, 32'h8);
        rd_chk("t3_status_clr", 32'h4, 32'h3);
        wait_frames(f0 + 5, 6000);
        check("t3_queue_drained", exp_q.size(), 0);
        repeat (50) @(posedge clk);
        #1;
        check("t3_exactly5", frames, f0 + 5);
        rd_chk("t3_status_end", 32'h4, 32'h4);

        // Push while full on the STOP->START pop edge, DIV=4
        bus_wr(32'h8, 32'h4);
        f0 = frames;
        push(8'h20, 4, 1'b1);
        e_cyc = cyc;
        push(8'h21, 4, 1'b1);
        push(8'h22, 4, 1'b1);
        push(8'h23, 4, 1'b1);
        push(8'h24, 4, 1'b1);
        while (cyc < e_cyc + 40) begin
            @(posedge clk);
            #1;
        end
        rd_chk("t4_full_before", 32'h4, 32'h3);
        push(8'h25, 4, 1'b1);
        rd_chk("t4_full_after", 32'h4, 32'h3);
        wait_frames(f0 + 6, 400);
        rd_chk("t4_status_end", 32'h4, 32'h4);

        // Asynchronous reset during DATA bit 3
        push(8'hF0, 4, 1'b1);
        e_cyc = cyc;
        while (cyc < e_cyc + 18) begin
            @(posedge clk);
            #1;
        end
        check("t5_line_low_before", uart_tx_o, 0);
        #1 reset = 1'b0;
        #1;
        check("t5_tx_high", uart_tx_o, 1);
        check("t5_irq", irq_o, 1);
        rd_chk("t5_status", 32'h4, 32'h4);
        rd_chk("t5_div", 32'h8, 32'h1B2);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        f0    = frames;
        stray = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_tx_o !== 1'b1) stray++;
        end
        @(posedge clk);
        #1;
        check("t5_no_residual", stray, 0);
        check("t5_no_frames", frames, f0);
        check("t5_queue", exp_q.size(), 0);

        // DIV=0 transmits as 1; DIV change mid-frame applies to the next frame
        bus_wr(32'h8, 32'h0);
        rd_chk("t6_div0", 32'h8, 32'h0);
        f0 = frames;
        push(8'hFF, 1, 1'b1);
        e_cyc = cyc;
        push(8'h3C, 8, 1'b1);
        bus_wr(32'h8, 32'h8);
        rd_chk("t6_div8", 32'h8, 32'h8);
        wait_frames(f0 + 2, 300);
        n = starts.size();
        check("t6_start1", starts[n-2], e_cyc + 1);
        check("t6_start2", starts[n-1], e_cyc + 11);
        check("t6_irq", irq_o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
